// File: rtl/block_buffer_ctrl_if.sv
// Handshake/bus bundle between the block buffer controller and its neighbours:
// the request-queue head, the block buffer datapath controls, the memory side
// and the requester response.
//   master : the controller (drives deq, buffer enables/selects, mem request, response)
//   slave  : the environment (request queue, memory, requester)
interface block_buffer_ctrl_if #(
    parameter int ADDR_WIDTH   = 64,
    parameter int SECTOR_IDX_W = 3
);
    // request queue head
    logic                    req_valid;
    logic                    req_is_write;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic                    req_deq;
    // block buffer datapath controls
    logic                    buf_wr_all;
    logic                    buf_wr_specific;
    logic [SECTOR_IDX_W-1:0] buf_sector_index;
    logic [SECTOR_IDX_W-1:0] buf_rd_sel;
    logic                    buf_fill_sel;
    // memory side
    logic                    mem_req_valid;
    logic                    mem_req_is_write;
    logic [ADDR_WIDTH-1:0]   mem_req_addr;
    logic                    mem_req_ready;
    logic                    mem_resp_valid;
    // requester response
    logic                    resp_valid;
    logic                    resp_ready;

    modport master (
        input  req_valid, req_is_write, req_addr, mem_req_ready, mem_resp_valid, resp_ready,
        output req_deq, buf_wr_all, buf_wr_specific, buf_sector_index, buf_rd_sel,
               buf_fill_sel, mem_req_valid, mem_req_is_write, mem_req_addr, resp_valid
    );

    modport slave (
        output req_valid, req_is_write, req_addr, mem_req_ready, mem_resp_valid, resp_ready,
        input  req_deq, buf_wr_all, buf_wr_specific, buf_sector_index, buf_rd_sel,
               buf_fill_sel, mem_req_valid, mem_req_is_write, mem_req_addr, resp_valid
    );
endinterface

// File: rtl/block_buffer_ctrl.sv
// Sequencer for a single-block (512-bit, 8 x 64-bit sector) buffer.
// Serves the head of the request queue: on a miss it writes back the dirty
// block, fills the new one from memory, then performs the sector access and
// returns a response, popping the queue when the requester accepts it.
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   bus (master)    request head, buffer controls, memory request/response, response
//   stat_hits       wrapping hit counter
//   stat_misses     wrapping miss counter
module block_buffer_ctrl #(
    parameter int ADDR_WIDTH   = 64,
    parameter int BLOCK_LSB    = 6,
    parameter int SECTOR_IDX_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    block_buffer_ctrl_if.master bus,
    output logic [31:0]         stat_hits,
    output logic [31:0]         stat_misses
);
    localparam int TAG_W = ADDR_WIDTH - BLOCK_LSB;

    typedef enum logic [2:0] {
        IDLE, WRITEBACK, FILL_REQ, FILL_WAIT, ACCESS, RESPOND
    } state_t;

    state_t             state, state_nxt;
    logic               blk_valid, blk_dirty;
    logic [TAG_W-1:0]   blk_tag;
    logic [TAG_W-1:0]   req_tag;
    logic               hit;

    // one-cycle events from the next-state logic that update the registers
    logic               ev_hit, ev_miss, ev_wb_done, ev_fill_done, ev_wr_access;

    assign req_tag = bus.req_addr[ADDR_WIDTH-1:BLOCK_LSB];
    assign hit     = blk_valid && (blk_tag == req_tag);

    // The queue head is held until req_deq, so the sector selects can follow
    // the request address directly in every state.
    assign bus.buf_sector_index = bus.req_addr[BLOCK_LSB-1 -: SECTOR_IDX_W];
    assign bus.buf_rd_sel       = bus.req_addr[BLOCK_LSB-1 -: SECTOR_IDX_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            blk_valid   <= 1'b0;
            blk_dirty   <= 1'b0;
            blk_tag     <= '0;
            stat_hits   <= '0;
            stat_misses <= '0;
        end else begin
            state <= state_nxt;
            if (ev_hit)
                stat_hits <= stat_hits + 32'd1;
            if (ev_miss)
                stat_misses <= stat_misses + 32'd1;
            if (ev_wb_done)
                blk_dirty <= 1'b0;
            if (ev_fill_done) begin
                blk_valid <= 1'b1;
                blk_tag   <= req_tag;
                blk_dirty <= 1'b0;
            end
            if (ev_wr_access)
                blk_dirty <= 1'b1;
        end
    end

    always_comb begin
        state_nxt            = state;
        bus.req_deq          = 1'b0;
        bus.buf_wr_all       = 1'b0;
        bus.buf_wr_specific  = 1'b0;
        bus.buf_fill_sel     = 1'b0;
        bus.mem_req_valid    = 1'b0;
        bus.mem_req_is_write = 1'b0;
        bus.mem_req_addr     = '0;
        bus.resp_valid       = 1'b0;
        ev_hit               = 1'b0;
        ev_miss              = 1'b0;
        ev_wb_done           = 1'b0;
        ev_fill_done         = 1'b0;
        ev_wr_access         = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (hit) begin
                        ev_hit    = 1'b1;
                        state_nxt = ACCESS;
                    end else begin
                        ev_miss   = 1'b1;
                        state_nxt = blk_dirty ? WRITEBACK : FILL_REQ;
                    end
                end
            end
            WRITEBACK: begin
                // Write transactions carry no response; acceptance is completion.
                bus.mem_req_valid    = 1'b1;
                bus.mem_req_is_write = 1'b1;
                bus.mem_req_addr     = {blk_tag, {BLOCK_LSB{1'b0}}};
                if (bus.mem_req_ready) begin
                    ev_wb_done = 1'b1;
                    state_nxt  = FILL_REQ;
                end
            end
            FILL_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = {req_tag, {BLOCK_LSB{1'b0}}};
                if (bus.mem_req_ready)
                    state_nxt = FILL_WAIT;
            end
            FILL_WAIT: begin
                // Fill data is on the buffer input only in the valid cycle.
                if (bus.mem_resp_valid) begin
                    bus.buf_wr_all   = 1'b1;
                    bus.buf_fill_sel = 1'b1;
                    ev_fill_done     = 1'b1;
                    state_nxt        = ACCESS;
                end
            end
            ACCESS: begin
                if (bus.req_is_write) begin
                    bus.buf_wr_specific = 1'b1;
                    ev_wr_access        = 1'b1;
                end
                state_nxt = RESPOND;
            end
            RESPOND: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    bus.req_deq = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_block_buffer_ctrl.sv
module tb_block_buffer_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] stat_hits, stat_misses;

    always #5 clk = ~clk;

    block_buffer_ctrl_if #(.ADDR_WIDTH(64), .SECTOR_IDX_W(3)) bus ();

    block_buffer_ctrl #(.ADDR_WIDTH(64), .BLOCK_LSB(6), .SECTOR_IDX_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .stat_hits  (stat_hits),
        .stat_misses(stat_misses)
    );

    int checks = 0;
    int errors = 0;

    // observations of the last transaction run by run_req
    int          o_wb, o_fill, o_wr_all, o_wr_spec, o_lat, o_deq, o_both;
    int          o_mem_cyc, o_resp_cyc, o_unstable, o_wb_cyc, o_fill_cyc, o_sel_bad;
    logic [63:0] o_wb_addr, o_fill_addr;
    logic [2:0]  o_spec_idx, o_rd_sel;
    bit          o_timeout;

    // Presents one request and plays memory/requester with the given delays.
    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic run_req(input logic wr, input logic [63:0] a,
                           input int rdy_dly, input int fill_dly, input int ack_dly);
        int          mwait = 0, fcnt = 0, rwait = 0;
        bit          fill_pend = 0, done = 0, prev_mv = 0, prev_rdy = 0;
        logic [63:0] prev_addr = '0;
        o_wb = 0; o_fill = 0; o_wr_all = 0; o_wr_spec = 0; o_lat = -1; o_deq = 0;
        o_both = 0; o_mem_cyc = 0; o_resp_cyc = 0; o_unstable = 0; o_sel_bad = 0;
        o_wb_cyc = -1; o_fill_cyc = -1; o_wb_addr = '0; o_fill_addr = '0;
        o_spec_idx = '0; o_rd_sel = '0;
        for (int c = 0; c < 500 && !done; c++) begin
            @(negedge clk);
            bus.req_valid      = 1'b1;
            bus.req_is_write   = wr;
            bus.req_addr       = a;
            bus.mem_req_ready  = bus.mem_req_valid && (mwait >= rdy_dly);
            bus.mem_resp_valid = fill_pend && (fcnt >= fill_dly);
            bus.resp_ready     = bus.resp_valid && (rwait >= ack_dly);
            #1;
            if (bus.buf_wr_all && bus.buf_wr_specific) o_both++;
            if (bus.buf_wr_all) begin
                o_wr_all++;
                if (!bus.buf_fill_sel) o_sel_bad++;
            end
            if (bus.buf_wr_specific) begin
                o_wr_spec++;
                o_spec_idx = bus.buf_sector_index;
                if (bus.buf_fill_sel) o_sel_bad++;
            end
            if (bus.mem_resp_valid) fill_pend = 0;
            else if (fill_pend) fcnt++;
            if (bus.mem_req_valid) begin
                o_mem_cyc++;
                if (prev_mv && !prev_rdy && bus.mem_req_addr !== prev_addr) o_unstable++;
                if (bus.mem_req_ready) begin
                    if (bus.mem_req_is_write) begin
                        o_wb++; o_wb_addr = bus.mem_req_addr; o_wb_cyc = c;
                    end else begin
                        o_fill++; o_fill_addr = bus.mem_req_addr; o_fill_cyc = c;
                        fill_pend = 1; fcnt = 0;
                    end
                    mwait = 0;
                end else begin
                    mwait++;
                end
            end else if (prev_mv && !prev_rdy) begin
                o_unstable++;
            end
            prev_mv = bus.mem_req_valid; prev_rdy = bus.mem_req_ready;
            prev_addr = bus.mem_req_addr;
            if (bus.resp_valid) begin
                if (o_lat < 0) begin o_lat = c; o_rd_sel = bus.buf_rd_sel; end
                o_resp_cyc++;
                if (!bus.resp_ready) rwait++;
            end
            if (bus.req_deq) begin o_deq++; done = 1; end
        end
        o_timeout = !done;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b0; bus.resp_ready = 1'b0;
        #1;
        if (bus.req_deq) o_deq++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid got %0b want 0", bus.mem_req_valid); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %0b want 0", bus.resp_valid); end
        checks++; if (bus.req_deq !== 1'b0) begin errors++; $display("FAIL reset_req_deq got %0b want 0", bus.req_deq); end
        checks++; if ({bus.buf_wr_all, bus.buf_wr_specific} !== 2'b00) begin errors++; $display("FAIL reset_wr_en got %b want 00", {bus.buf_wr_all, bus.buf_wr_specific}); end
        checks++; if (stat_hits !== 32'd0) begin errors++; $display("FAIL reset_stat_hits got %0d want 0", stat_hits); end
        checks++; if (stat_misses !== 32'd0) begin errors++; $display("FAIL reset_stat_misses got %0d want 0", stat_misses); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fill_miss();
        run_req(1'b0, 64'h1008, 0, 1, 0);
        checks++; if (o_timeout) begin errors++; $display("FAIL miss_timeout got 1 want 0"); end
        checks++; if (o_fill !== 1 || o_wb !== 0) begin errors++; $display("FAIL miss_mem_txn got fill=%0d wb=%0d want fill=1 wb=0", o_fill, o_wb); end
        checks++; if (o_fill_addr !== 64'h1000) begin errors++; $display("FAIL miss_fill_addr got %0h want 1000", o_fill_addr); end
        checks++; if (o_wr_all !== 1) begin errors++; $display("FAIL miss_wr_all_cycles got %0d want 1", o_wr_all); end
        checks++; if (o_rd_sel !== 3'd1) begin errors++; $display("FAIL miss_rd_sel got %0d want 1", o_rd_sel); end
        checks++; if (stat_misses !== 32'd1 || stat_hits !== 32'd0) begin errors++; $display("FAIL miss_stats got h=%0d m=%0d want h=0 m=1", stat_hits, stat_misses); end
        checks++; if (o_deq !== 1) begin errors++; $display("FAIL miss_deq_count got %0d want 1", o_deq); end
    endtask

    task automatic test_hit();
        run_req(1'b0, 64'h1038, 0, 1, 0);
        checks++; if (o_lat !== 2) begin errors++; $display("FAIL hit_latency got %0d want 2", o_lat); end
        checks++; if (o_rd_sel !== 3'd7) begin errors++; $display("FAIL hit_rd_sel got %0d want 7", o_rd_sel); end
        checks++; if (o_mem_cyc !== 0) begin errors++; $display("FAIL hit_mem_req_cycles got %0d want 0", o_mem_cyc); end
        checks++; if (stat_hits !== 32'd1) begin errors++; $display("FAIL hit_stat_hits got %0d want 1", stat_hits); end
        checks++; if (o_wr_all !== 0 || o_wr_spec !== 0) begin errors++; $display("FAIL hit_read_wr_en got all=%0d spec=%0d want 0 0", o_wr_all, o_wr_spec); end
    endtask

    task automatic test_write_wb();
        run_req(1'b1, 64'h1010, 0, 1, 0);
        checks++; if (o_wr_spec !== 1) begin errors++; $display("FAIL wr_spec_cycles got %0d want 1", o_wr_spec); end
        checks++; if (o_spec_idx !== 3'd2) begin errors++; $display("FAIL wr_spec_index got %0d want 2", o_spec_idx); end
        checks++; if (stat_hits !== 32'd2) begin errors++; $display("FAIL wr_stat_hits got %0d want 2", stat_hits); end
        run_req(1'b0, 64'h2000, 0, 1, 0);
        checks++; if (o_wb !== 1) begin errors++; $display("FAIL wb_count got %0d want 1", o_wb); end
        checks++; if (o_wb_addr !== 64'h1000) begin errors++; $display("FAIL wb_addr got %0h want 1000", o_wb_addr); end
        checks++; if (o_fill !== 1 || o_fill_addr !== 64'h2000) begin errors++; $display("FAIL wb_fill got n=%0d addr=%0h want n=1 addr=2000", o_fill, o_fill_addr); end
        checks++; if (!(o_wb_cyc >= 0 && o_wb_cyc < o_fill_cyc)) begin errors++; $display("FAIL wb_order got wb_cyc=%0d fill_cyc=%0d want wb first", o_wb_cyc, o_fill_cyc); end
        checks++; if (stat_misses !== 32'd2) begin errors++; $display("FAIL wb_stat_misses got %0d want 2", stat_misses); end
    endtask

    task automatic test_stall();
        run_req(1'b0, 64'h4008, 5, 1, 3);
        checks++; if (o_unstable !== 0) begin errors++; $display("FAIL stall_mem_stability got %0d violations want 0", o_unstable); end
        checks++; if (o_mem_cyc !== 6) begin errors++; $display("FAIL stall_mem_valid_cycles got %0d want 6", o_mem_cyc); end
        checks++; if (o_fill_addr !== 64'h4000) begin errors++; $display("FAIL stall_fill_addr got %0h want 4000", o_fill_addr); end
        checks++; if (o_resp_cyc !== 4) begin errors++; $display("FAIL stall_resp_valid_cycles got %0d want 4", o_resp_cyc); end
        checks++; if (o_deq !== 1) begin errors++; $display("FAIL stall_deq_count got %0d want 1", o_deq); end
    endtask

    task automatic test_back_to_back();
        run_req(1'b0, 64'h5000, 0, 0, 0);
        checks++; if (stat_misses !== 32'd4) begin errors++; $display("FAIL b2b_stat_misses got %0d want 4", stat_misses); end
        run_req(1'b0, 64'h5038, 0, 0, 0);
        checks++; if (o_lat !== 2 || o_mem_cyc !== 0) begin errors++; $display("FAIL b2b_hit got lat=%0d mem=%0d want lat=2 mem=0", o_lat, o_mem_cyc); end
        checks++; if (stat_hits !== 32'd3) begin errors++; $display("FAIL b2b_stat_hits got %0d want 3", stat_hits); end
    endtask

    task automatic test_reset_fill_wait();
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_is_write = 1'b0; bus.req_addr = 64'h6000;
        @(negedge clk);                       // FILL_REQ
        bus.mem_req_ready = 1'b1;
        #1;
        checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL rfw_fill_req got %0b want 1", bus.mem_req_valid); end
        @(negedge clk);                       // FILL_WAIT
        bus.mem_req_ready = 1'b0;
        #2 rst = 1'b0;
        bus.mem_resp_valid = 1'b1;
        #1;
        checks++; if (bus.buf_wr_all !== 1'b0) begin errors++; $display("FAIL rfw_wr_all_in_reset got %0b want 0", bus.buf_wr_all); end
        checks++; if (bus.mem_req_valid !== 1'b0 || bus.resp_valid !== 1'b0 || bus.req_deq !== 1'b0) begin errors++; $display("FAIL rfw_outputs got mv=%0b rv=%0b dq=%0b want 0 0 0", bus.mem_req_valid, bus.resp_valid, bus.req_deq); end
        checks++; if (stat_hits !== 32'd0 || stat_misses !== 32'd0) begin errors++; $display("FAIL rfw_stats got h=%0d m=%0d want 0 0", stat_hits, stat_misses); end
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.buf_wr_all !== 1'b0) begin errors++; $display("FAIL rfw_late_resp_wr_all got %0b want 0", bus.buf_wr_all); end
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        run_req(1'b0, 64'h6008, 0, 1, 0);
        checks++; if (o_fill !== 1) begin errors++; $display("FAIL rfw_rerequest_fill got %0d want 1", o_fill); end
        checks++; if (stat_misses !== 32'd1 || stat_hits !== 32'd0) begin errors++; $display("FAIL rfw_rerequest_stats got h=%0d m=%0d want 0 1", stat_hits, stat_misses); end
    endtask

    task automatic test_random();
        bit          mv = 0, md = 0, h;
        logic [57:0] mt = '0, old_tag;
        int          eh = 0, em = 0, bad = 0, tmo = 0, both = 0, ewb;
        logic [63:0] a;
        logic        w;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a = 64'h8000 + 64'($urandom_range(0, 3)) * 64'h40 + 64'($urandom_range(0, 7)) * 64'h8;
            w = 1'($urandom_range(0, 1));
            h = mv && (mt == a[63:6]);
            ewb = (!h && mv && md) ? 1 : 0;
            old_tag = mt;
            if (h) eh++;
            else begin em++; mv = 1; mt = a[63:6]; md = 0; end
            if (w) md = 1;
            run_req(w, a, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
            if (o_timeout) begin tmo++; break; end
            both += o_both;
            if (o_deq != 1 || o_wb != ewb || o_fill != (h ? 0 : 1) || o_sel_bad != 0 || o_unstable != 0
                || (ewb == 1 && o_wb_addr !== {old_tag, 6'd0}))
                bad++;
        end
        checks++; if (tmo !== 0) begin errors++; $display("FAIL rand_timeout got %0d want 0", tmo); end
        checks++; if (stat_hits !== 32'(eh)) begin errors++; $display("FAIL rand_stat_hits got %0d want %0d", stat_hits, eh); end
        checks++; if (stat_misses !== 32'(em)) begin errors++; $display("FAIL rand_stat_misses got %0d want %0d", stat_misses, em); end
        checks++; if (both !== 0) begin errors++; $display("FAIL rand_both_wr_en got %0d want 0", both); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rand_txn_mismatch got %0d bad requests want 0", bad); end
    endtask

    initial begin
        rst = 1'b0;
        bus.req_valid = 1'b0; bus.req_is_write = 1'b0; bus.req_addr = '0;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.resp_ready = 1'b0;
        test_reset();
        test_fill_miss();
        test_hit();
        test_write_wb();
        test_stall();
        test_back_to_back();
        test_reset_fill_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
